dump_ctrl_gen: RTL and testbench

- Parametrised capture-RAM dump controller.
- Sits between the host command decoder, the EEPROM SPI master, the channel RAM interface and the UART response transmitter.
- On a dump command it latches the channel and start address, then reads that channel's gain/offset calibration from EEPROM over SPI.
- It then streams a programmable number of samples to the UART, incrementing the RAM address after each one, and signals completion.

---
 rtl/dump_pkg.sv | 37 +++
 rtl/dump_len_cnt.sv | 45 ++++
 rtl/dump_ctrl_gen.sv | 171 +++++++++++++++++
 tb/tb_dump_ctrl_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// dump_pkg: shared types, EEPROM command layout and command builder for the capture-RAM dump controller.
//   Exports: dump_state_e (controller states), EE_* field positions and values, build_ee_cmd().
package dump_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_GAIN   = 4'd1,
        RD_OFFSET = 4'd2,
        RD_JUNK   = 4'd3,
        EE_WAIT   = 4'd4,
        UART_WAIT = 4'd5,
        INC       = 4'd6,
        CHECK     = 4'd7,
        DONE      = 4'd8
    } dump_state_e;

    // EEPROM read command: {prefix[15:14], ch[13:12], gain[11:9], sel[8], 8'h00}
    localparam logic [1:0] EE_PREFIX     = 2'b00;
    localparam int         EE_PREFIX_LSB = 14;
    localparam int         EE_CH_LSB     = 12;
    localparam int         EE_GAIN_LSB   = 9;
    localparam int         EE_SEL_BIT    = 8;
    localparam logic       EE_SEL_GAIN   = 1'b1;
    localparam logic       EE_SEL_OFFSET = 1'b0;

    function automatic logic [15:0] build_ee_cmd(input logic [1:0] ch, input logic [2:0] gain,
                                                 input logic sel);
        logic [15:0] cmd;
        cmd = '0;
        cmd[EE_PREFIX_LSB +: 2] = EE_PREFIX;
        cmd[EE_CH_LSB +: 2]     = ch;
        cmd[EE_GAIN_LSB +: 3]   = gain;
        cmd[EE_SEL_BIT]         = sel;
        return cmd;
    endfunction

endpackage

// File: rtl/dump_len_cnt.sv
// dump_len_cnt: latches the effective dump length and counts samples sent.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch effective length from dump_len and clear the counter
//   inc        : advance the sample counter by one
//   dump_len   : requested length; 0 or anything above the RAM depth means full depth
//   done       : counter has reached the latched length
module dump_len_cnt
    import dump_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    input  logic [ADDR_W:0] dump_len,
    output logic            done
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [ADDR_W:0] eff_len;

    always_comb begin
        eff_len = (dump_len == '0 || dump_len > DEPTH) ? DEPTH : dump_len;
        len_d   = load ? eff_len : len_q;
        cnt_d   = load ? '0 : inc ? cnt_q + (ADDR_W+1)'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

    // Completion is counter-based so a full-depth dump from any start address sends exactly DEPTH samples.
    assign done = cnt_q == len_q;

endmodule

// File: rtl/dump_ctrl_gen.sv
// dump_ctrl_gen: capture-RAM dump controller (EEPROM calibration fetch over SPI, then sample stream to UART).
//   Optional feature macro: DUMP_ABORT_EN (adds abort input and dump_aborted output).
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_dump      : single-cycle request, honoured only in IDLE
//   channel         : requested channel
//   dump_len        : samples to send (0 or > RAM depth means full depth)
//   afe_gain        : packed per-channel gain codes
//   addr            : external RAM address counter
//   spi_rdy/uart_rdy: SPI master / UART transmitter ready
//   start_spi, spi_tx_data, flop_gain, flop_offset : EEPROM transaction control
//   start_uart, inc_addr : sample send and address advance pulses
//   ch_sel, dump_en, dump_done, dump_err : latched channel and status
//   abort, dump_aborted  : (DUMP_ABORT_EN only) forced return to IDLE
module dump_ctrl_gen
    import dump_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 9,
    parameter int GAIN_W = 3,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_dump,
    input  logic [CH_W-1:0]          channel,
    input  logic [ADDR_W:0]          dump_len,
    input  logic [NUM_CH*GAIN_W-1:0] afe_gain,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     spi_rdy,
    input  logic                     uart_rdy,
    output logic                     start_spi,
    output logic [15:0]              spi_tx_data,
    output logic                     flop_gain,
    output logic                     flop_offset,
    output logic                     start_uart,
    output logic                     inc_addr,
    output logic [CH_W-1:0]          ch_sel,
    output logic                     dump_en,
    output logic                     dump_done,
    output logic                     dump_err
`ifdef DUMP_ABORT_EN
    ,
    input  logic                     abort,
    output logic                     dump_aborted
`endif
);

    dump_state_e       state_q, state_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [2:0]        gsel;
    logic              ch_ok;
    logic              load;
    logic              cnt_done;
    logic              unused_start_addr;

    dump_len_cnt #(.ADDR_W(ADDR_W)) u_len_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .inc      (inc_addr),
        .dump_len (dump_len),
        .done     (cnt_done)
    );

    // Gain code of the latched channel, zero-extended to the 3-bit command field.
    always_comb begin
        gsel = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_sel_q == CH_W'(i)) gsel = 3'(afe_gain[i*GAIN_W +: GAIN_W]);
    end

    assign ch_ok = 32'(channel) < NUM_CH;

    always_comb begin
        state_d      = state_q;
        ch_sel_d     = ch_sel_q;
        start_addr_d = start_addr_q;
        load         = 1'b0;
        start_spi    = 1'b0;
        spi_tx_data  = '0;
        flop_gain    = 1'b0;
        flop_offset  = 1'b0;
        start_uart   = 1'b0;
        inc_addr     = 1'b0;
        dump_done    = 1'b0;
        dump_err     = 1'b0;
`ifdef DUMP_ABORT_EN
        dump_aborted = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_dump && ch_ok) begin
                    load         = 1'b1;
                    ch_sel_d     = channel;
                    start_addr_d = addr;
                    state_d      = RD_GAIN;
                end
                dump_err = start_dump && !ch_ok;
            end
            RD_GAIN: if (spi_rdy) begin
                start_spi   = 1'b1;
                spi_tx_data = build_ee_cmd(ch_sel_q, gsel, EE_SEL_GAIN);
                state_d     = RD_OFFSET;
            end
            RD_OFFSET: if (spi_rdy) begin
                start_spi   = 1'b1;
                spi_tx_data = build_ee_cmd(ch_sel_q, gsel, EE_SEL_OFFSET);
                state_d     = RD_JUNK;
            end
            // The gain word arrives while the dummy transaction clocks out the offset word.
            RD_JUNK: if (spi_rdy) begin
                flop_gain   = 1'b1;
                start_spi   = 1'b1;
                spi_tx_data = build_ee_cmd(ch_sel_q, gsel, EE_SEL_OFFSET);
                state_d     = EE_WAIT;
            end
            EE_WAIT: if (spi_rdy) begin
                flop_offset = 1'b1;
                state_d     = UART_WAIT;
            end
            UART_WAIT: if (uart_rdy) begin
                start_uart = 1'b1;
                state_d    = INC;
            end
            INC: begin
                inc_addr = 1'b1;
                state_d  = CHECK;
            end
            CHECK: state_d = cnt_done ? DONE : UART_WAIT;
            DONE: if (uart_rdy) begin
                dump_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef DUMP_ABORT_EN
        // Abort overrides every transition and suppresses all handshake pulses.
        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            start_spi    = 1'b0;
            spi_tx_data  = '0;
            flop_gain    = 1'b0;
            flop_offset  = 1'b0;
            start_uart   = 1'b0;
            inc_addr     = 1'b0;
            dump_done    = 1'b0;
            dump_aborted = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_sel_q     <= '0;
            start_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            ch_sel_q     <= ch_sel_d;
            start_addr_q <= start_addr_d;
        end
    end

    // The start address is held for the dump's duration but completion never consults it.
    assign unused_start_addr = ^start_addr_q;

    assign ch_sel  = ch_sel_q;
    assign dump_en = state_q != IDLE;

endmodule

// File: tb/tb_dump_ctrl_gen.sv
// tb_dump_ctrl_gen: directed self-checking bench for dump_ctrl_gen.
module tb_dump_ctrl_gen;

    logic        clk;
    logic        rst_n;
    logic        start_dump;
    logic [1:0]  channel;
    logic [9:0]  dump_len;
    logic [8:0]  afe_gain;
    logic [8:0]  addr;
    logic        spi_rdy;
    logic        uart_rdy;
    logic        start_spi;
    logic [15:0] spi_tx_data;
    logic        flop_gain;
    logic        flop_offset;
    logic        start_uart;
    logic        inc_addr;
    logic [1:0]  ch_sel;
    logic        dump_en;
    logic        dump_done;
    logic        dump_err;
`ifdef DUMP_ABORT_EN
    logic        abort;
    logic        dump_aborted;
    int          c_abt;
`endif

    int checks;
    int failures;
    int c_spi, c_fg, c_fo, c_uart, c_inc, c_done, c_err;
    logic [15:0] tx_log [0:63];

    dump_ctrl_gen #(.NUM_CH(3), .ADDR_W(9), .GAIN_W(3), .CH_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_dump  (start_dump),
        .channel     (channel),
        .dump_len    (dump_len),
        .afe_gain    (afe_gain),
        .addr        (addr),
        .spi_rdy     (spi_rdy),
        .uart_rdy    (uart_rdy),
        .start_spi   (start_spi),
        .spi_tx_data (spi_tx_data),
        .flop_gain   (flop_gain),
        .flop_offset (flop_offset),
        .start_uart  (start_uart),
        .inc_addr    (inc_addr),
        .ch_sel      (ch_sel),
        .dump_en     (dump_en),
        .dump_done   (dump_done),
        .dump_err    (dump_err)
`ifdef DUMP_ABORT_EN
        ,
        .abort        (abort),
        .dump_aborted (dump_aborted)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM address counter, wrapping modulo depth.
    always @(posedge clk) if (inc_addr) addr <= addr + 9'd1;

    always @(negedge clk) begin
        if (start_spi) begin
            if (c_spi < 64) tx_log[c_spi] <= spi_tx_data;
            c_spi <= c_spi + 1;
        end
        if (flop_gain) c_fg <= c_fg + 1;
        if (flop_offset) c_fo <= c_fo + 1;
        if (start_uart) c_uart <= c_uart + 1;
        if (inc_addr) c_inc <= c_inc + 1;
        if (dump_done) c_done <= c_done + 1;
        if (dump_err) c_err <= c_err + 1;
`ifdef DUMP_ABORT_EN
        if (dump_aborted) c_abt <= c_abt + 1;
`endif
    end

    task automatic start_req(input logic [1:0] ch, input logic [9:0] len, input logic [8:0] a);
        @(posedge clk); #1;
        channel = ch; dump_len = len; addr = a; start_dump = 1'b1;
        @(posedge clk); #1;
        start_dump = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!dump_en) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_spi, flop_gain, flop_offset, start_uart, inc_addr, dump_en, dump_done, dump_err} !== 8'h00) begin
            failures++;
            $display("FAIL reset_pulses: got %b expected 00000000",
                     {start_spi, flop_gain, flop_offset, start_uart, inc_addr, dump_en, dump_done, dump_err});
        end
        checks++;
        if (spi_tx_data !== 16'h0000 || ch_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_data: got tx=%h ch_sel=%0d expected tx=0000 ch_sel=0", spi_tx_data, ch_sel);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dump_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got dump_en=%b expected 0", dump_en);
        end
    endtask

    task automatic test_basic;
        int b_spi, b_fg, b_fo, b_uart, b_inc, b_done;
        bit ok;
        b_spi = c_spi; b_fg = c_fg; b_fo = c_fo; b_uart = c_uart; b_inc = c_inc; b_done = c_done;
        start_req(2'd1, 10'd4, 9'h010);
        @(negedge clk);
        checks++;
        if (start_spi !== 1'b1 || spi_tx_data !== 16'h1700) begin
            failures++;
            $display("FAIL basic_latency: got start_spi=%b tx=%h expected 1 1700", start_spi, spi_tx_data);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout: got dump_en=%b expected 0 within 100 cycles", dump_en);
        end
        checks++;
        if (c_spi - b_spi !== 3) begin
            failures++;
            $display("FAIL basic_spi_cnt: got %0d expected 3", c_spi - b_spi);
        end
        checks++;
        if (tx_log[b_spi] !== 16'h1700 || tx_log[b_spi+1] !== 16'h1600 || tx_log[b_spi+2] !== 16'h1600) begin
            failures++;
            $display("FAIL basic_cmds: got %h %h %h expected 1700 1600 1600",
                     tx_log[b_spi], tx_log[b_spi+1], tx_log[b_spi+2]);
        end
        checks++;
        if (c_fg - b_fg !== 1 || c_fo - b_fo !== 1) begin
            failures++;
            $display("FAIL basic_flops: got gain=%0d offset=%0d expected 1 1", c_fg - b_fg, c_fo - b_fo);
        end
        checks++;
        if (c_uart - b_uart !== 4 || c_inc - b_inc !== 4) begin
            failures++;
            $display("FAIL basic_samples: got uart=%0d inc=%0d expected 4 4", c_uart - b_uart, c_inc - b_inc);
        end
        checks++;
        if (c_done - b_done !== 1) begin
            failures++;
            $display("FAIL basic_done: got %0d expected 1", c_done - b_done);
        end
        checks++;
        if (ch_sel !== 2'd1 || addr !== 9'h014) begin
            failures++;
            $display("FAIL basic_state: got ch_sel=%0d addr=%h expected 1 014", ch_sel, addr);
        end
    endtask

    task automatic test_bad_channel;
        int b_spi, b_err;
        b_spi = c_spi; b_err = c_err;
        @(posedge clk); #1;
        channel = 2'd3; start_dump = 1'b1;
        @(negedge clk);
        checks++;
        if (dump_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_err_pulse: got %b expected 1", dump_err);
        end
        @(posedge clk); #1;
        start_dump = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (c_err - b_err !== 1 || c_spi - b_spi !== 0 || dump_en !== 1'b0) begin
            failures++;
            $display("FAIL bad_effects: got err=%0d spi=%0d dump_en=%b expected 1 0 0",
                     c_err - b_err, c_spi - b_spi, dump_en);
        end
        checks++;
        if (ch_sel !== 2'd1) begin
            failures++;
            $display("FAIL bad_ch_hold: got %0d expected 1", ch_sel);
        end
    endtask

    task automatic test_full_depth;
        int b_uart, b_done, b_spi;
        bit ok;
        b_uart = c_uart; b_done = c_done; b_spi = c_spi;
        start_req(2'd0, 10'd0, 9'h1F0);
        wait_idle(2000, ok);
        checks++;
        if (!ok || c_uart - b_uart !== 512 || c_done - b_done !== 1) begin
            failures++;
            $display("FAIL full_len0: got ok=%b uart=%0d done=%0d expected 1 512 1", ok, c_uart - b_uart, c_done - b_done);
        end
        checks++;
        if (addr !== 9'h1F0 || tx_log[b_spi] !== 16'h0300) begin
            failures++;
            $display("FAIL full_wrap: got addr=%h tx=%h expected 1f0 0300", addr, tx_log[b_spi]);
        end
        b_uart = c_uart; b_done = c_done;
        start_req(2'd2, 10'd700, 9'h005);
        wait_idle(2000, ok);
        checks++;
        if (!ok || c_uart - b_uart !== 512 || c_done - b_done !== 1) begin
            failures++;
            $display("FAIL full_len700: got ok=%b uart=%0d done=%0d expected 1 512 1", ok, c_uart - b_uart, c_done - b_done);
        end
        b_uart = c_uart; b_done = c_done;
        start_req(2'd2, 10'd1, 9'h1FF);
        wait_idle(100, ok);
        checks++;
        if (!ok || c_uart - b_uart !== 1 || c_done - b_done !== 1 || addr !== 9'h000) begin
            failures++;
            $display("FAIL len_one: got ok=%b uart=%0d done=%0d addr=%h expected 1 1 1 000",
                     ok, c_uart - b_uart, c_done - b_done, addr);
        end
    endtask

    task automatic test_stall;
        int b_spi, b_uart, b_done;
        bit ok;
        b_spi = c_spi; b_uart = c_uart; b_done = c_done;
        spi_rdy = 1'b0; uart_rdy = 1'b0;
        start_req(2'd2, 10'd2, 9'h020);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (c_spi - b_spi !== 0 || dump_en !== 1'b1) begin
            failures++;
            $display("FAIL stall_spi: got spi=%0d dump_en=%b expected 0 1", c_spi - b_spi, dump_en);
        end
        @(posedge clk); #1;
        spi_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start_dump = (i == 10);
            channel = 2'd0;
        end
        start_dump = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (c_uart - b_uart !== 0 || c_spi - b_spi !== 3 || ch_sel !== 2'd2) begin
            failures++;
            $display("FAIL stall_uart: got uart=%0d spi=%0d ch_sel=%0d expected 0 3 2",
                     c_uart - b_uart, c_spi - b_spi, ch_sel);
        end
        checks++;
        if (tx_log[b_spi] !== 16'h2500 || tx_log[b_spi+1] !== 16'h2400) begin
            failures++;
            $display("FAIL stall_cmds: got %h %h expected 2500 2400", tx_log[b_spi], tx_log[b_spi+1]);
        end
        @(posedge clk); #1;
        uart_rdy = 1'b1;
        wait_idle(50, ok);
        checks++;
        if (!ok || c_uart - b_uart !== 2 || c_done - b_done !== 1 || ch_sel !== 2'd2) begin
            failures++;
            $display("FAIL stall_finish: got ok=%b uart=%0d done=%0d ch_sel=%0d expected 1 2 1 2",
                     ok, c_uart - b_uart, c_done - b_done, ch_sel);
        end
    endtask

    task automatic test_reset_mid;
        int b_uart, b_done;
        bit hit;
        b_uart = c_uart; b_done = c_done; hit = 1'b0;
        start_req(2'd1, 10'd8, 9'h000);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (c_uart - b_uart >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rmid_timeout: got uart=%0d expected 2 within 100 cycles", c_uart - b_uart);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_spi, flop_gain, flop_offset, start_uart, inc_addr, dump_en, dump_done, dump_err} !== 8'h00
            || spi_tx_data !== 16'h0000 || ch_sel !== 2'd0) begin
            failures++;
            $display("FAIL rmid_async: got pulses=%b tx=%h ch_sel=%0d expected 00000000 0000 0",
                     {start_spi, flop_gain, flop_offset, start_uart, inc_addr, dump_en, dump_done, dump_err},
                     spi_tx_data, ch_sel);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (c_done - b_done !== 0 || dump_en !== 1'b0) begin
            failures++;
            $display("FAIL rmid_no_done: got done=%0d dump_en=%b expected 0 0", c_done - b_done, dump_en);
        end
    endtask

`ifdef DUMP_ABORT_EN
    task automatic test_abort;
        int b_fg, b_abt;
        b_fg = c_fg; b_abt = c_abt;
        start_req(2'd1, 10'd4, 9'h000);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if (dump_aborted !== 1'b1 || flop_gain !== 1'b0 || start_spi !== 1'b0) begin
            failures++;
            $display("FAIL abort_cycle: got aborted=%b flop_gain=%b start_spi=%b expected 1 0 0",
                     dump_aborted, flop_gain, start_spi);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (dump_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got dump_en=%b expected 0", dump_en);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (c_fg - b_fg !== 0 || c_abt - b_abt !== 1) begin
            failures++;
            $display("FAIL abort_counts: got flop_gain=%0d aborted=%0d expected 0 1", c_fg - b_fg, c_abt - b_abt);
        end
    endtask
`endif

    initial begin
        checks = 0; failures = 0;
        c_spi = 0; c_fg = 0; c_fo = 0; c_uart = 0; c_inc = 0; c_done = 0; c_err = 0;
        rst_n = 1'b0; start_dump = 1'b0; channel = 2'd0; dump_len = 10'd0; addr = 9'd0;
        afe_gain = {3'b010, 3'b011, 3'b001};
        spi_rdy = 1'b1; uart_rdy = 1'b1;
`ifdef DUMP_ABORT_EN
        abort = 1'b0; c_abt = 0;
`endif
        test_reset;
        test_basic;
        test_bad_channel;
        test_full_depth;
        test_stall;
        test_reset_mid;
`ifdef DUMP_ABORT_EN
        test_abort;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
